// File: rtl/xmit_pkg.sv
// Shared types and control-block layout for the transmit priority scheduler.
package xmit_pkg;

    localparam int CTRL_W     = 24;
    localparam int LEN_W      = 12;
    localparam int LEN_LSB    = 0;
    localparam int LENCHK_LSB = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER,
        ST_DISCARD,
        ST_IFG
    } state_t;

endpackage

// File: rtl/xmit_ctrl_check.sv
// Combinational decode of a 24-bit control block: frame length plus
// validity (redundant length copy matches, length within legal bounds).
module xmit_ctrl_check
    import xmit_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic [CTRL_W-1:0] ctrl,
    output logic [LEN_W-1:0]  len,
    output logic              valid
);

    logic [LEN_W-1:0] len_chk;

    assign len     = ctrl[LEN_LSB +: LEN_W];
    assign len_chk = ctrl[LENCHK_LSB +: LEN_W];
    assign valid   = (len_chk == len)
                   && (len >= LEN_W'(MIN_LEN))
                   && (len <= LEN_W'(MAX_LEN));

endmodule

// File: rtl/xmit_prio_sched.sv
// Frame-level transmit scheduler: strict hi/lo priority arbitration, control
// block validation, byte streaming with inter-frame gap, and drain of bad frames.
// Optional starvation guard for low priority: define XMIT_STARVE_GUARD_EN.
module xmit_prio_sched
    import xmit_pkg::*;
#(
    parameter int MIN_LEN      = 64,
    parameter int MAX_LEN      = 1518,
    parameter int IFG_CYCLES   = 12,
    parameter int MAX_HI_BURST = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              hi_ctrl_valid,
    input  logic [CTRL_W-1:0] hi_ctrl,
    output logic              hi_ctrl_pop,
    input  logic [7:0]        hi_data,
    output logic              hi_data_rd,
    input  logic              lo_ctrl_valid,
    input  logic [CTRL_W-1:0] lo_ctrl,
    output logic              lo_ctrl_pop,
    input  logic [7:0]        lo_data,
    output logic              lo_data_rd,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_sof,
    output logic              tx_eof,
    output logic              m_discard_en,
    output logic              cur_prio,
    output logic              busy
);

    localparam int IFG_W = 16;

    state_t           state_reg, state_next;
    logic             sel_reg, sel_next;
    logic             cur_prio_reg, cur_prio_next;
    logic [LEN_W-1:0] remain_reg, remain_next;
    logic             sof_reg, sof_next;
    logic [IFG_W-1:0] ifg_reg, ifg_next;

    logic             grant_hi;
    logic [CTRL_W-1:0] ctrl_head;
    logic [LEN_W-1:0] ctrl_len;
    logic             ctrl_ok;
    logic [7:0]       data_head;

    // sel_reg remembers the queue chosen in IDLE; everything after muxes on it
    assign ctrl_head = sel_reg ? hi_ctrl : lo_ctrl;
    assign data_head = sel_reg ? hi_data : lo_data;

    xmit_ctrl_check #(
        .MIN_LEN (MIN_LEN),
        .MAX_LEN (MAX_LEN)
    ) u_ctrl_check (
        .ctrl  (ctrl_head),
        .len   (ctrl_len),
        .valid (ctrl_ok)
    );

`ifdef XMIT_STARVE_GUARD_EN
    logic [15:0] streak_reg, streak_next;

    assign grant_hi = hi_ctrl_valid
                    && !(lo_ctrl_valid && (streak_reg == 16'(MAX_HI_BURST)));

    always_comb begin
        streak_next = streak_reg;
        if (state_reg == ST_IDLE) begin
            if (!lo_ctrl_valid)
                streak_next = '0;
            else if (grant_hi)
                streak_next = streak_reg + 16'd1;
            else
                streak_next = '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            streak_reg <= '0;
        else
            streak_reg <= streak_next;
    end
`else
    assign grant_hi = hi_ctrl_valid;
`endif

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        cur_prio_next = cur_prio_reg;
        remain_next   = remain_reg;
        sof_next      = sof_reg;
        ifg_next      = ifg_reg;
        hi_ctrl_pop   = 1'b0;
        lo_ctrl_pop   = 1'b0;
        hi_data_rd    = 1'b0;
        lo_data_rd    = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        tx_sof        = 1'b0;
        tx_eof        = 1'b0;
        m_discard_en  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (hi_ctrl_valid || lo_ctrl_valid) begin
                    sel_next   = grant_hi;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                hi_ctrl_pop   = sel_reg;
                lo_ctrl_pop   = !sel_reg;
                cur_prio_next = sel_reg;
                remain_next   = ctrl_len;
                sof_next      = 1'b1;
                if (ctrl_ok)
                    state_next = ST_XFER;
                else if (ctrl_len != '0)
                    state_next = ST_DISCARD;
                else
                    state_next = ST_IDLE;
            end
            ST_XFER: begin
                tx_valid = 1'b1;
                tx_data  = data_head;
                tx_sof   = sof_reg;
                tx_eof   = (remain_reg == LEN_W'(1));
                if (tx_ready) begin
                    hi_data_rd  = sel_reg;
                    lo_data_rd  = !sel_reg;
                    remain_next = remain_reg - LEN_W'(1);
                    sof_next    = 1'b0;
                    if (remain_reg == LEN_W'(1)) begin
                        if (IFG_CYCLES == 0) begin
                            state_next = ST_IDLE;
                        end else begin
                            state_next = ST_IFG;
                            ifg_next   = IFG_W'(IFG_CYCLES - 1);
                        end
                    end
                end
            end
            ST_DISCARD: begin
                m_discard_en = 1'b1;
                hi_data_rd   = sel_reg;
                lo_data_rd   = !sel_reg;
                remain_next  = remain_reg - LEN_W'(1);
                if (remain_reg == LEN_W'(1))
                    state_next = ST_IDLE;
            end
            ST_IFG: begin
                if (ifg_reg == '0)
                    state_next = ST_IDLE;
                else
                    ifg_next = ifg_reg - IFG_W'(1);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            sel_reg      <= 1'b0;
            cur_prio_reg <= 1'b0;
            remain_reg   <= '0;
            sof_reg      <= 1'b0;
            ifg_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            cur_prio_reg <= cur_prio_next;
            remain_reg   <= remain_next;
            sof_reg      <= sof_next;
            ifg_reg      <= ifg_next;
        end
    end

    assign cur_prio = cur_prio_reg;
    assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_xmit_prio_sched.sv
// Directed bench for xmit_prio_sched: vector table of single frames plus
// sequences for back-to-back gap, stalls, starvation guard and mid-frame reset.
module tb_xmit_prio_sched;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        hi_ctrl_valid, lo_ctrl_valid;
    logic [23:0] hi_ctrl, lo_ctrl;
    logic        hi_ctrl_pop, lo_ctrl_pop;
    logic [7:0]  hi_data, lo_data;
    logic        hi_data_rd, lo_data_rd;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, tx_sof, tx_eof;
    logic        m_discard_en, cur_prio, busy;

    xmit_prio_sched #(
        .MIN_LEN      (64),
        .MAX_LEN      (1518),
        .IFG_CYCLES   (12),
        .MAX_HI_BURST (4)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .hi_ctrl_valid (hi_ctrl_valid),
        .hi_ctrl       (hi_ctrl),
        .hi_ctrl_pop   (hi_ctrl_pop),
        .hi_data       (hi_data),
        .hi_data_rd    (hi_data_rd),
        .lo_ctrl_valid (lo_ctrl_valid),
        .lo_ctrl       (lo_ctrl),
        .lo_ctrl_pop   (lo_ctrl_pop),
        .lo_data       (lo_data),
        .lo_data_rd    (lo_data_rd),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_sof        (tx_sof),
        .tx_eof        (tx_eof),
        .m_discard_en  (m_discard_en),
        .cur_prio      (cur_prio),
        .busy          (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int failures = 0;

    logic [23:0] hi_q[$];
    logic [23:0] lo_q[$];
    int hi_ptr = 0;
    int lo_ptr = 0;
    int cyc_no = 0;
    int ready_mode = 0;

    logic       c_hi_pop, c_lo_pop, c_hi_rd, c_lo_rd;
    logic       c_valid, c_sof, c_eof, c_disc, c_prio, c_busy, c_ready;
    logic [7:0] c_data;

    int r_pop_cyc, r_first_v_cyc, r_eof_cyc;

    typedef struct {
        logic        hi;
        logic [23:0] ctrl;
        logic        exp_prio;
        int          exp_beats;
        int          exp_disc;
        int          exp_ifg;
        int          exp_rd;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [7:0] mk(input logic prio, input int ptr);
        return {prio, 7'(ptr)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive();
        hi_ctrl_valid = (hi_q.size() != 0);
        hi_ctrl       = (hi_q.size() != 0) ? hi_q[0] : 24'h0;
        lo_ctrl_valid = (lo_q.size() != 0);
        lo_ctrl       = (lo_q.size() != 0) ? lo_q[0] : 24'h0;
        hi_data       = mk(1'b1, hi_ptr);
        lo_data       = mk(1'b0, lo_ptr);
        if (ready_mode == 0)
            tx_ready = 1'b1;
        else
            tx_ready = ((cyc_no % 4) == 0) || ((cyc_no % 4) == 3);
    endtask

    // One clock: sample outputs mid-cycle, then advance the FIFO model past the edge.
    task automatic cyc();
        @(negedge clk_sys);
        c_hi_pop = hi_ctrl_pop;
        c_lo_pop = lo_ctrl_pop;
        c_hi_rd  = hi_data_rd;
        c_lo_rd  = lo_data_rd;
        c_valid  = tx_valid;
        c_sof    = tx_sof;
        c_eof    = tx_eof;
        c_disc   = m_discard_en;
        c_prio   = cur_prio;
        c_busy   = busy;
        c_data   = tx_data;
        c_ready  = tx_ready;
        if ($countones({c_hi_pop, c_lo_pop, c_hi_rd, c_lo_rd}) > 1)
            check("strobe_exclusive", 32'($countones({c_hi_pop, c_lo_pop, c_hi_rd, c_lo_rd})), 32'd1);
        @(posedge clk_sys);
        #1;
        cyc_no++;
        if (c_hi_pop && hi_q.size() != 0) void'(hi_q.pop_front());
        if (c_lo_pop && lo_q.size() != 0) void'(lo_q.pop_front());
        if (c_hi_rd) hi_ptr++;
        if (c_lo_rd) lo_ptr++;
        drive();
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " tx_valid"}, 32'(c_valid), 32'd0);
        check({name, " tx_sof"}, 32'(c_sof), 32'd0);
        check({name, " tx_eof"}, 32'(c_eof), 32'd0);
        check({name, " tx_data"}, 32'(c_data), 32'd0);
        check({name, " discard"}, 32'(c_disc), 32'd0);
        check({name, " cur_prio"}, 32'(c_prio), 32'd0);
        check({name, " busy"}, 32'(c_busy), 32'd0);
        check({name, " strobes"}, 32'({c_hi_pop, c_lo_pop, c_hi_rd, c_lo_rd}), 32'd0);
    endtask

    // Follows one frame from its control pop until the scheduler is back in IDLE.
    task automatic run_frame(input string name, input logic exp_prio, input int exp_beats,
                             input int exp_disc, input int exp_ifg, input int exp_rd,
                             input bit check_lat);
        int t = 0;
        int pop_at = -1;
        int first_v = -1;
        int beats = 0;
        int disc = 0;
        int ifg = 0;
        int rds = 0;
        int data_err = 0;
        int flag_err = 0;
        int prio_err = 0;
        int base = 0;
        logic got_prio = 1'b0;
        bit done = 0;
        while (!done && t < 4000) begin
            cyc();
            t++;
            if (pop_at < 0) begin
                if (c_hi_pop || c_lo_pop) begin
                    pop_at    = t;
                    r_pop_cyc = cyc_no;
                    got_prio  = c_hi_pop;
                    base      = c_hi_pop ? hi_ptr : lo_ptr;
                end
            end else begin
                if (c_hi_rd || c_lo_rd) rds++;
                if (c_disc) disc++;
                if (c_valid) begin
                    if (first_v < 0) begin
                        first_v       = t;
                        r_first_v_cyc = cyc_no;
                    end
                    if (c_data !== mk(got_prio, base + beats)) data_err++;
                    if (c_prio !== got_prio) prio_err++;
                    if (c_sof !== (beats == 0)) flag_err++;
                    if (c_eof !== (beats == exp_beats - 1)) flag_err++;
                    if (c_ready) begin
                        if (c_eof) r_eof_cyc = cyc_no;
                        beats++;
                    end
                end else begin
                    if (c_data !== 8'h00) data_err++;
                    if (c_sof || c_eof) flag_err++;
                end
                if (c_busy && !c_valid && !c_disc) ifg++;
                if (!c_busy) done = 1;
            end
        end
        if (!done) check({name, " timeout"}, 32'd0, 32'd1);
        check({name, " grant_prio"}, 32'(got_prio), 32'(exp_prio));
        check({name, " beats"}, 32'(beats), 32'(exp_beats));
        check({name, " discard_cycles"}, 32'(disc), 32'(exp_disc));
        check({name, " gap_cycles"}, 32'(ifg), 32'(exp_ifg));
        check({name, " data_rd"}, 32'(rds), 32'(exp_rd));
        check({name, " data_errs"}, 32'(data_err), 32'd0);
        check({name, " sof_eof_errs"}, 32'(flag_err), 32'd0);
        if (check_lat) check({name, " pop_latency"}, 32'(pop_at), 32'd2);
        if (exp_beats > 0) begin
            check({name, " sof_latency"}, 32'(first_v - pop_at), 32'd1);
            check({name, " cur_prio"}, 32'(prio_err), 32'd0);
        end
        $display("frame %s: prio=%0d beats=%0d discard=%0d gap=%0d rd=%0d", name, got_prio,
                 beats, disc, ifg, rds);
    endtask

    initial begin
        logic exp_order[7];
        int   gap_pop, gap_sof, bound;

        vecs[0] = '{1'b0, 24'h040040, 1'b0, 64,   0,    12, 64};
        vecs[1] = '{1'b1, 24'h040040, 1'b1, 64,   0,    12, 64};
        vecs[2] = '{1'b0, 24'h040041, 1'b0, 0,    65,   0,  65};
        vecs[3] = '{1'b1, 24'h000000, 1'b1, 0,    0,    0,  0};
        vecs[4] = '{1'b1, 24'h5EE5EE, 1'b1, 1518, 0,    12, 1518};
        vecs[5] = '{1'b0, 24'h5EF5EF, 1'b0, 0,    1519, 0,  1519};
        vecs[6] = '{1'b0, 24'h03F03F, 1'b0, 0,    63,   0,  63};
        vecs[7] = '{1'b1, 24'h041041, 1'b1, 65,   0,    12, 65};
        vecs[8] = '{1'b1, 24'h001001, 1'b1, 0,    1,    0,  1};

        reset = 1'b1;
        drive();
        cyc();
        cyc();
        check_idle_outputs("reset");
        reset = 1'b0;
        cyc();
        check_idle_outputs("post_reset_idle");

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].hi) hi_q.push_back(vecs[i].ctrl);
            else            lo_q.push_back(vecs[i].ctrl);
            drive();
            run_frame($sformatf("vec%0d", i), vecs[i].exp_prio, vecs[i].exp_beats,
                      vecs[i].exp_disc, vecs[i].exp_ifg, vecs[i].exp_rd, 1'b1);
        end

        // Both queues pending: hi first, lo follows after the gap plus one IDLE cycle.
        hi_q.push_back(24'h040040);
        lo_q.push_back(24'h040040);
        drive();
        run_frame("b2b_hi", 1'b1, 64, 0, 12, 64, 1'b1);
        gap_pop = r_eof_cyc;
        run_frame("b2b_lo", 1'b0, 64, 0, 12, 64, 1'b0);
        check("b2b lo_pop_after_eof", 32'(r_pop_cyc - gap_pop), 32'd14);
        gap_sof = r_first_v_cyc - gap_pop;
        check("b2b lo_sof_after_eof", 32'(gap_sof), 32'd15);

        // Serializer stalls with ready pattern 1,0,0,1.
        ready_mode = 1;
        lo_q.push_back(24'h040040);
        drive();
        run_frame("stall", 1'b0, 64, 0, 12, 64, 1'b0);
        ready_mode = 0;
        drive();

        // Hi always pending while one lo frame waits.
`ifdef XMIT_STARVE_GUARD_EN
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        for (int i = 0; i < 6; i++) hi_q.push_back(24'h040040);
        lo_q.push_back(24'h040040);
        drive();
        for (int i = 0; i < 7; i++)
            run_frame($sformatf("starve%0d", i), exp_order[i], 64, 0, 12, 64, 1'b0);

        // Reset while byte 20 is on the bus.
        lo_q.push_back(24'h040040);
        drive();
        bound = 0;
        begin
            int seen = 0;
            while (seen < 20 && bound < 200) begin
                cyc();
                bound++;
                if (c_valid && c_ready) seen++;
            end
            if (seen < 20) check("midreset reach_byte20", 32'(seen), 32'd20);
        end
        check("midreset byte20_valid", 32'(tx_valid), 32'd1);
        reset = 1'b1;
        cyc();
        cyc();
        check_idle_outputs("midreset");
        reset = 1'b0;
        lo_q.delete();
        hi_q.push_back(24'h040040);
        drive();
        run_frame("after_reset", 1'b1, 64, 0, 12, 64, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
